// File: rtl/ft232h_pkg.sv
// Shared types and constants for the FT232H 245 synchronous FIFO interface.
package ft232h_pkg;

    localparam int FT232H_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        TX_WRITE,
        RX_OE,
        RX_READ,
        RX_DRAIN,
        TURN
    } ft232h_if_state_t;

endpackage

// File: rtl/ft232h_rx_skid.sv
// Two-entry byte FIFO between the FT232H read strobe and the RX AXI-Stream output.
module ft232h_rx_skid
    import ft232h_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic [FT232H_DATA_W-1:0]  push_data,
    output logic [FT232H_DATA_W-1:0]  tdata,
    output logic                      tvalid,
    input  logic                      tready,
    output logic [1:0]                count,
    output logic                      full,
    output logic                      almost_full
);

    logic [FT232H_DATA_W-1:0] mem [2];
    logic                     wr_ptr;
    logic                     rd_ptr;
    logic                     pop;

    assign pop         = tvalid && tready;
    assign tvalid      = (count != 2'd0);
    assign full        = (count == 2'd2);
    assign almost_full = (count != 2'd0);
    assign tdata       = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // The read throttle upstream must never let a byte arrive with both slots occupied.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/ft232h_sync_fifo_if.sv
// FT232H 245 synchronous FIFO master: AXIS TX bytes become device writes, device reads become AXIS RX bytes.
module ft232h_sync_fifo_if
    import ft232h_pkg::*;
#(
    parameter int TX_BURST_MAX = 64,
    parameter bit RX_PRIORITY  = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rxf_n,
    input  logic                      txe_n,
    input  logic [FT232H_DATA_W-1:0]  data_in,
    output logic [FT232H_DATA_W-1:0]  data_out,
    output logic                      data_oe,
    output logic                      rd_n,
    output logic                      wr_n,
    output logic                      oe_n,
    output logic                      siwu_n,
    input  logic [FT232H_DATA_W-1:0]  tx_tdata,
    input  logic                      tx_tvalid,
    output logic                      tx_tready,
    output logic [FT232H_DATA_W-1:0]  rx_tdata,
    output logic                      rx_tvalid,
    input  logic                      rx_tready
);

    ft232h_if_state_t         state, state_d;
    logic                     hold_valid, hold_valid_d;
    logic [FT232H_DATA_W-1:0] hold_data;
    logic [7:0]               burst_cnt, burst_d;
    logic                     rd_n_d, wr_n_d, oe_n_d, data_oe_d;
    logic                     wr_fire, rd_fire, tx_beat, rx_pop;
    logic                     rx_req, tx_req;
    logic [1:0]               fifo_count, count_d;
    logic                     fifo_full, fifo_almost_full;

    assign wr_fire      = !wr_n && !txe_n;
    assign rd_fire      = !oe_n && !rd_n && !rxf_n;
    assign tx_tready    = rst_n && (state == IDLE || state == TX_WRITE) && (!hold_valid || wr_fire);
    assign tx_beat      = tx_tvalid && tx_tready;
    assign hold_valid_d = (hold_valid && !wr_fire) || tx_beat;
    assign rx_pop       = rx_tvalid && rx_tready;
    assign count_d      = fifo_count + {1'b0, rd_fire} - {1'b0, rx_pop};
    assign rx_req       = !rxf_n && !fifo_full;
    assign tx_req       = (hold_valid || tx_tvalid) && !txe_n;
    assign data_out     = hold_data;
    assign siwu_n       = 1'b1;

    ft232h_rx_skid u_rx_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (rd_fire),
        .push_data   (data_in),
        .tdata       (rx_tdata),
        .tvalid      (rx_tvalid),
        .tready      (rx_tready),
        .count       (fifo_count),
        .full        (fifo_full),
        .almost_full (fifo_almost_full)
    );

    // Because rd_n is registered, reading continues only while the FIFO will be empty after this edge.
    always_comb begin
        state_d   = state;
        burst_d   = burst_cnt;
        rd_n_d    = 1'b1;
        oe_n_d    = oe_n;
        data_oe_d = data_oe;
        case (state)
            IDLE: begin
                burst_d = 8'd0;
                if (rx_req && (RX_PRIORITY || !tx_req)) begin
                    state_d   = RX_OE;
                    oe_n_d    = 1'b0;
                    data_oe_d = 1'b0;
                end else if (tx_req) begin
                    state_d   = TX_WRITE;
                    data_oe_d = 1'b1;
                end
            end
            TX_WRITE: begin
                burst_d = burst_cnt + {7'd0, wr_fire};
                if (!hold_valid_d || txe_n || burst_d == 8'(TX_BURST_MAX)) begin
                    state_d = IDLE;
                end
            end
            RX_OE: begin
                if (!rxf_n && !fifo_almost_full) begin
                    state_d = RX_READ;
                    rd_n_d  = 1'b0;
                end else begin
                    state_d = RX_DRAIN;
                end
            end
            RX_READ: begin
                if (rxf_n || count_d != 2'd0) begin
                    state_d = RX_DRAIN;
                end else begin
                    rd_n_d = 1'b0;
                end
            end
            RX_DRAIN: begin
                state_d = TURN;
                oe_n_d  = 1'b1;
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        wr_n_d = !(state_d == TX_WRITE && hold_valid_d);
    end

    // A byte that met txe_n high stays in hold_data and is resent on the next TX_WRITE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            burst_cnt  <= 8'd0;
            rd_n       <= 1'b1;
            wr_n       <= 1'b1;
            oe_n       <= 1'b1;
            data_oe    <= 1'b0;
        end else begin
            state      <= state_d;
            hold_valid <= hold_valid_d;
            if (tx_beat) begin
                hold_data <= tx_tdata;
            end
            burst_cnt  <= burst_d;
            rd_n       <= rd_n_d;
            wr_n       <= wr_n_d;
            oe_n       <= oe_n_d;
            data_oe    <= data_oe_d;
        end
    end

endmodule
